// File: rtl/sw_select_reader.sv
// Slide-switch / confirm-button front end: synchronises and debounces SW and KEY,
// decodes the stable switch pattern into value/error/none and issues confirm pulses.
module sw_select_reader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] SW,
    input  logic       KEY,
    output logic [7:0] value,
    output logic       error,
    output logic       none,
    output logic       sel_valid,
    output logic       sel_reject,
    output logic [7:0] sel_value
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Two-flop synchronisers
    logic [9:0]       sw_s1_q, sw_s2_q;
    logic             key_s1_q, key_s2_q;

    // Switch debounce
    logic [9:0]       sw_cand_q, sw_cand_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [9:0]       sw_stable_q, sw_stable_d;

    // Key debounce
    logic             key_cand_q, key_cand_d;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic             key_stable_q, key_stable_d;
    logic             key_prev_q, key_prev_d;

    // Decode registers
    logic [7:0]       value_q, value_d;
    logic             error_q, error_d;
    logic             none_q, none_d;

    // Confirm FSM
    state_t           state_q, state_d;
    logic             sel_valid_q, sel_valid_d;
    logic             sel_reject_q, sel_reject_d;
    logic [7:0]       sel_value_q, sel_value_d;
    logic             key_fall;

    always_comb begin
        sw_cand_d   = sw_cand_q;
        sw_cnt_d    = sw_cnt_q;
        sw_stable_d = sw_stable_q;
        // Any bit differing from the candidate restarts the whole window.
        if (sw_s2_q != sw_cand_q) begin
            sw_cand_d = sw_s2_q;
            sw_cnt_d  = '0;
        end else if (sw_cnt_q == CNT_MAX) begin
            sw_stable_d = sw_cand_q;
        end else begin
            sw_cnt_d = sw_cnt_q + 1'b1;
        end
    end

    always_comb begin
        key_cand_d   = key_cand_q;
        key_cnt_d    = key_cnt_q;
        key_stable_d = key_stable_q;
        key_prev_d   = key_stable_q;
        if (key_s2_q != key_cand_q) begin
            key_cand_d = key_s2_q;
            key_cnt_d  = '0;
        end else if (key_cnt_q == CNT_MAX) begin
            key_stable_d = key_cand_q;
        end else begin
            key_cnt_d = key_cnt_q + 1'b1;
        end
    end

    logic [3:0] pop;
    logic [2:0] idx;

    always_comb begin
        pop = 4'd0;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, sw_stable_q[i]};
            if (sw_stable_q[i]) idx = 3'(i);
        end
        none_d  = (sw_stable_q == 10'd0);
        error_d = !none_d && ((sw_stable_q[9:8] != 2'b00) || (pop > 4'd1));
        value_d = (!none_d && !error_d) ? {5'b00000, idx} : 8'd0;
    end

    assign key_fall = key_prev_q && !key_stable_q;

    // Decisions use the already-registered decode, so a switch commit landing
    // on the same edge as a press is judged against the old selection.
    always_comb begin
        state_d      = state_q;
        sel_valid_d  = 1'b0;
        sel_reject_d = 1'b0;
        sel_value_d  = sel_value_q;
        case (state_q)
            IDLE: begin
                if (key_fall) begin
                    if (!error_q && !none_q) begin
                        sel_valid_d = 1'b1;
                        sel_value_d = value_q;
                    end else begin
                        sel_reject_d = 1'b1;
                    end
                    state_d = HELD;
                end
            end
            HELD: begin
                if (key_stable_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            sw_cand_q    <= '0;
            sw_cnt_q     <= '0;
            sw_stable_q  <= '0;
            key_cand_q   <= 1'b1;
            key_cnt_q    <= '0;
            key_stable_q <= 1'b1;
            key_prev_q   <= 1'b1;
            value_q      <= 8'd0;
            error_q      <= 1'b0;
            none_q       <= 1'b1;
            state_q      <= IDLE;
            sel_valid_q  <= 1'b0;
            sel_reject_q <= 1'b0;
            sel_value_q  <= 8'd0;
        end else begin
            sw_s1_q      <= SW;
            sw_s2_q      <= sw_s1_q;
            key_s1_q     <= KEY;
            key_s2_q     <= key_s1_q;
            sw_cand_q    <= sw_cand_d;
            sw_cnt_q     <= sw_cnt_d;
            sw_stable_q  <= sw_stable_d;
            key_cand_q   <= key_cand_d;
            key_cnt_q    <= key_cnt_d;
            key_stable_q <= key_stable_d;
            key_prev_q   <= key_prev_d;
            value_q      <= value_d;
            error_q      <= error_d;
            none_q       <= none_d;
            state_q      <= state_d;
            sel_valid_q  <= sel_valid_d;
            sel_reject_q <= sel_reject_d;
            sel_value_q  <= sel_value_d;
        end
    end

    assign value      = value_q;
    assign error      = error_q;
    assign none       = none_q;
    assign sel_valid  = sel_valid_q;
    assign sel_reject = sel_reject_q;
    assign sel_value  = sel_value_q;

endmodule

// File: tb/tb_sw_select_reader.sv
// Bench for sw_select_reader with a 4-cycle debounce window.
module tb_sw_select_reader;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] SW;
    logic       KEY;
    logic [7:0] value;
    logic       error;
    logic       none;
    logic       sel_valid;
    logic       sel_reject;
    logic [7:0] sel_value;

    sw_select_reader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SW         (SW),
        .KEY        (KEY),
        .value      (value),
        .error      (error),
        .none       (none),
        .sel_valid  (sel_valid),
        .sel_reject (sel_reject),
        .sel_value  (sel_value)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [9:0] exp_q[$];
    logic [9:0] last_exp;
    logic [7:0] exp_sel_q[$];
    int         n_vec;
    int         n_miss;
    int         valid_cycles;
    int         reject_cycles;
    int         both_cycles;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sel_valid === 1'b1) valid_cycles++;
            if (sel_reject === 1'b1) reject_cycles++;
            if (sel_valid === 1'b1 && sel_reject === 1'b1) both_cycles++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {none, error, value[7:0]}
    function automatic logic [9:0] ref_decode(input logic [9:0] s);
        logic [7:0] onehot;
        if (s == 10'd0) return {1'b1, 1'b0, 8'd0};
        if (s[9:8] != 2'b00) return {1'b0, 1'b1, 8'd0};
        for (int i = 0; i < 8; i++) begin
            onehot = 8'd1 << i;
            if (s[7:0] == onehot) return {1'b0, 1'b0, 8'(i)};
        end
        return {1'b0, 1'b1, 8'd0};
    endfunction

    function automatic logic [9:0] observed();
        return {none, error, value};
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive a new steady SW level; outputs must hold through edge 7, update on edge 8.
    task automatic apply_sw(input logic [9:0] v, input string tag);
        logic [9:0] e;
        exp_q.push_back(ref_decode(v));
        @(negedge clk);
        SW = v;
        wait_cycles(D + 3);
        check_val({tag, "_hold"}, 32'(observed()), 32'(last_exp));
        wait_cycles(1);
        e = exp_q.pop_front();
        check_val({tag, "_dec"}, 32'(observed()), 32'(e));
        last_exp = e;
    endtask

    task automatic press_key(input int hold, input int gap);
        @(negedge clk);
        KEY = 1'b0;
        wait_cycles(hold);
        KEY = 1'b1;
        wait_cycles(gap);
    endtask

    task automatic check_pulses(input string tag, input int exp_v, input int exp_r);
        logic [7:0] es;
        check_val({tag, "_valid_cnt"}, 32'(valid_cycles), 32'(exp_v));
        check_val({tag, "_reject_cnt"}, 32'(reject_cycles), 32'(exp_r));
        es = exp_sel_q.pop_front();
        check_val({tag, "_sel_value"}, 32'(sel_value), 32'(es));
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        valid_cycles = 0;
        reject_cycles = 0;
        both_cycles = 0;
        SW = 10'd0;
        KEY = 1'b1;
        rst_n = 1'b1;

        // asynchronous reset applied mid-cycle
        #12;
        rst_n = 1'b0;
        #1;
        check_val("rst_decode", 32'(observed()), 32'(ref_decode(10'd0)));
        check_val("rst_pulses", 32'({sel_valid, sel_reject}), 32'd0);
        check_val("rst_sel_value", 32'(sel_value), 32'd0);
        last_exp = ref_decode(10'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        apply_sw(10'h008, "single_sw3");
        apply_sw(10'h000, "back_none");

        // bounce faster than the window: decode must never move
        for (int i = 0; i < 15; i++) begin
            SW = (i % 2 == 0) ? 10'h008 : 10'h000;
            wait_cycles(2);
            check_val("bounce", 32'(observed()), 32'(ref_decode(10'd0)));
        end
        SW = 10'h000;
        wait_cycles(D + 6);
        check_val("bounce_settled", 32'(observed()), 32'(ref_decode(10'd0)));

        apply_sw(10'h009, "illegal_two");
        apply_sw(10'h100, "illegal_sw8");
        apply_sw(10'h000, "none_again");
        for (int i = 0; i < 3; i++) begin
            logic [9:0] r;
            r = 10'(1) << $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) r = r | (10'(1) << $urandom_range(0, 9));
            apply_sw(r, "random");
        end

        // accepted confirm, long hold gives one pulse
        apply_sw(10'h020, "sel5");
        valid_cycles = 0;
        reject_cycles = 0;
        press_key(100, 12);
        exp_sel_q.push_back(8'd5);
        check_pulses("accept1", 1, 0);
        press_key(20, 12);
        exp_sel_q.push_back(8'd5);
        check_pulses("accept2", 2, 0);

        // rejected confirm keeps previous selection
        apply_sw(10'h200, "sel_sw9");
        valid_cycles = 0;
        reject_cycles = 0;
        @(negedge clk);
        KEY = 1'b0;
        wait_cycles(20);
        exp_sel_q.push_back(8'd5);
        check_pulses("reject", 0, 1);

        // reset while key held: exactly one fresh pulse after release
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_decode", 32'(observed()), 32'(ref_decode(10'd0)));
        check_val("midrst_sel_value", 32'(sel_value), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_cycles = 0;
        reject_cycles = 0;
        wait_cycles(30);
        check_val("midrst_pulses", 32'(valid_cycles + reject_cycles), 32'd1);
        check_val("midrst_decode_after", 32'(observed()), 32'(ref_decode(10'h200)));
        KEY = 1'b1;
        wait_cycles(12);
        check_val("midrst_no_extra", 32'(valid_cycles + reject_cycles), 32'd1);
        check_val("exclusive", 32'(both_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sw_select_reader.md
# sw_select_reader

Input-side counterpart of the two-digit display path: reads the ten board slide switches and the confirm push-button, and debounces both. It decodes the switch pattern into the `value`/`error`/`none` triple the display driver consumes. It also issues a one-cycle commit pulse when the player confirms a legal selection.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: stability window in clocks (10 ms at 50 MHz). Legal range is ≥ 2. Benches use 4.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `SW`  in  10  raw slide switches, active-high, asynchronous to `clk`
- `KEY`  in  1  raw confirm button, active-low (0 = pressed), asynchronous
- `value`  out  8  index 0–7 of the single active switch; 0 when `error` or `none`
- `error`  out  1  illegal pattern: more than one of SW[7:0] on, or SW8/SW9 on
- `none`  out  1  all ten switches off
- `sel_valid`  out  1  one-cycle pulse: confirm accepted
- `sel_reject`  out  1  one-cycle pulse: confirm pressed while `error` or `none`
- `sel_value`  out  8  index captured at the last accepted confirm

## Operation
- **Synchronisation:** a two-flop synchroniser per input bit.
  - SW flops reset to 0.
  - KEY flops reset to 1.
- **Switch debounce:** one shared counter `cnt` and a 10-bit candidate `cand`.
  - If the synchronised SW ≠ `cand`: load `cand` from the synchronised SW and clear `cnt`.
  - Else if `cnt` == DEBOUNCE_CYCLES−1: `sw_stable` <= `cand`, and `cnt` holds.
  - Else: `cnt` increments.
  - Any bit change restarts the whole window.
- **Decode:** registered from `sw_stable`, evaluated in priority order.
  - `none` = 1 if all bits are 0.
  - Otherwise `error` = 1 if SW[9:8] ≠ 0 or popcount(SW[7:0]) > 1.
  - Otherwise `value` = bit index of the set bit, zero-extended to 8 bits.
  - `none` and `error` are never both 1.
- **Key debounce:** an identical, independent counter/candidate pair produces `key_stable`. Its reset value is 1 (released).
- **Confirm FSM** states:
  - IDLE: on a `key_stable` falling edge, evaluate the registered outputs.
    - Legal (`!error && !none`): `sel_valid` = 1 for one cycle, `sel_value` <= `value`. Go to HELD.
    - Illegal: `sel_reject` = 1 for one cycle, `sel_value` unchanged. Go to HELD.
  - HELD: no pulses. When `key_stable` returns to 1, go to IDLE.
- **Simultaneous events:** if a switch commit and a key press land on the same edge, the decision uses the registered outputs from before that edge, i.e. the old selection.
- **Reset mid-operation:**
  - All state clears immediately and asynchronously.
  - The FSM returns to IDLE.
  - A key held through reset is seen as a fresh press once it has been stable for DEBOUNCE_CYCLES after reset release, giving exactly one pulse.

## Timing
- **Reset values:**
  - `value` = 0, `error` = 0, `none` = 1
  - `sel_valid` = 0, `sel_reject` = 0, `sel_value` = 0
  - `sw_stable` = 0, `key_stable` = 1, both counters 0
- **Switch latency:** count as edge 1 the first rising edge that samples a new, steady SW level. `value`/`error`/`none` update on edge DEBOUNCE_CYCLES+4 (edge 8 for D = 4).
- **Key latency:** count as edge 1 the first edge sampling KEY = 0 steady. `key_stable` falls on edge D+3, and the pulse is asserted during the cycle after edge D+4.
- **Pulses:**
  - Exactly one clock wide.
  - `sel_valid` and `sel_reject` are mutually exclusive.
  - At most one pulse per press, regardless of hold time.
- **Glitch rejection:** any input level shorter than DEBOUNCE_CYCLES consecutive samples never reaches the outputs.
- **Counter width:** $clog2(DEBOUNCE_CYCLES). The counter never wraps; it saturates at D−1.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset:** assert `rst_n` = 0 mid-cycle → outputs are `none` = 1, `error` = 0, `value` = 0, no pulses, with no clock needed.
- **Single switch:** set SW = 10'h008 steady → `value` = 3, `none` = 0, `error` = 0 from edge 8 onward, unchanged before edge 8.
- **Bounce:** toggle SW between 10'h008 and 10'h000 every 2 cycles for 30 cycles, then hold 10'h000 → `none` stays 1 throughout, `value` never leaves 0.
- **Illegal patterns:**
  - SW = 10'h009 → `error` = 1, `value` = 0.
  - SW = 10'h100 → `error` = 1.
  - SW = 10'h000 → `none` = 1, `error` = 0.
- **Accepted confirm:** SW = 10'h020 settled, KEY held low for 100 cycles → exactly one `sel_valid` pulse, `sel_value` = 5, no `sel_reject`. After release and a second press: exactly one more pulse.
- **Rejected confirm and reset mid-operation:**
  - SW = 10'h200 settled, KEY pressed → one `sel_reject` pulse, `sel_value` keeps its prior value of 5.
  - Pulse `rst_n` low while KEY is still held → after release of reset, exactly one pulse appears.
